boundary_cell: RTL

//  Diagonal (boundary) cell of the triangularisation systolic array; directly upstream of internal_cell.

---
 rtl/boundary_cell_pkg.sv | 26 ++
 rtl/boundary_cell_div.sv | 73 +++++++
 rtl/boundary_cell.sv | 91 +++++++++
 3 files changed

// File: rtl/boundary_cell_pkg.sv
// Shared float32 field layout and helpers for the triangularisation array cells.
`default_nettype none

package boundary_cell_pkg;

   localparam int FP_W      = 32;
   localparam int FP_SIGN   = 31;
   localparam int FP_MAG_HI = 30;
   localparam int FP_MAG_LO = 0;

   // +0 and -0 are both zero; only the magnitude field is inspected.
   function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
      return (v[FP_MAG_HI:FP_MAG_LO] == '0);
   endfunction

   function automatic logic fp_mag_gt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
      return (a[FP_MAG_HI:FP_MAG_LO] > b[FP_MAG_HI:FP_MAG_LO]);
   endfunction

   function automatic logic [FP_W-1:0] fp_neg(input logic [FP_W-1:0] v);
      return {~v[FP_SIGN], v[FP_MAG_HI:FP_MAG_LO]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/boundary_cell_div.sv
// Combinational float32 divide, round-to-nearest-even; subnormals flush to zero.
`default_nettype none

module boundary_cell_div
   import boundary_cell_pkg::*;
(
   input  logic [FP_W-1:0] a_i,
   input  logic [FP_W-1:0] b_i,
   output logic [FP_W-1:0] result_o
);

   logic              sign;
   logic              a_zero;
   logic              b_zero;
   logic [23:0]       mb;
   logic [24:0]       rem;
   logic [26:0]       quo;
   logic signed [9:0] exp_raw;
   logic signed [9:0] exp_n;
   logic signed [9:0] exp_f;
   logic [23:0]       mant;
   logic              guard;
   logic              sticky;
   logic [24:0]       mant_r;
   logic [22:0]       frac;

   always_comb begin
      sign    = a_i[FP_SIGN] ^ b_i[FP_SIGN];
      a_zero  = (a_i[30:23] == 8'd0);
      b_zero  = (b_i[30:23] == 8'd0);
      mb      = {1'b1, b_i[22:0]};
      rem     = {2'b01, a_i[22:0]};
      quo     = '0;
      // Restoring division yields 27 quotient bits of ma*2^26/mb.
      for (int i = 26; i >= 0; i--) begin
         if (rem >= {1'b0, mb}) begin
            quo[i] = 1'b1;
            rem    = rem - {1'b0, mb};
         end
         rem = {rem[23:0], 1'b0};
      end
      exp_raw = {2'b00, a_i[30:23]} - {2'b00, b_i[30:23]} + 10'sd127;
      if (quo[26]) begin
         mant   = quo[26:3];
         guard  = quo[2];
         sticky = (|quo[1:0]) | (|rem);
         exp_n  = exp_raw;
      end else begin
         mant   = quo[25:2];
         guard  = quo[1];
         sticky = quo[0] | (|rem);
         exp_n  = exp_raw - 10'sd1;
      end
      mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
      if (mant_r[24]) begin
         exp_f = exp_n + 10'sd1;
         frac  = mant_r[23:1];
      end else begin
         exp_f = exp_n;
         frac  = mant_r[22:0];
      end
      if (a_zero || exp_f <= 10'sd0) begin
         result_o = {sign, 31'd0};
      end else if (b_zero || exp_f >= 10'sd255) begin
         result_o = {sign, 8'hFF, 23'd0};
      end else begin
         result_o = {sign, exp_f[7:0], frac};
      end
   end

endmodule

`default_nettype wire

// File: rtl/boundary_cell.sv
// Diagonal cell of the triangularisation array: holds the pivot, decides swap,
// and issues the elimination coefficient to the internal cell on its right.
`default_nettype none

module boundary_cell
   import boundary_cell_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             operation,
   input  logic             clr,
   input  logic [WIDTH-1:0] x_in,
   output logic [WIDTH-1:0] c_out,
   output logic             s_out,
   output logic [WIDTH-1:0] p_out,
   output logic [CNT_W-1:0] swap_cnt,
   output logic             singular
);

   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sing_q, sing_d;
   logic             swap;
   logic             p_zero;
   logic [WIDTH-1:0] div_a, div_b, div_res;

   assign swap   = operation & fp_mag_gt(x_in, p_q);
   assign p_zero = fp_is_zero(p_q);

   // On a swap the roles invert so the new pivot always sits in the divisor.
   assign div_a = swap ? p_q  : x_in;
   assign div_b = swap ? x_in : p_q;

   boundary_cell_div u_div (
      .a_i      (div_a),
      .b_i      (div_b),
      .result_o (div_res)
   );

   always_comb begin
      p_d    = p_q;
      c_d    = '0;
      s_d    = 1'b0;
      cnt_d  = cnt_q;
      sing_d = sing_q;
      if (clr) begin
         p_d    = '0;
         cnt_d  = '0;
         sing_d = 1'b0;
      end else if (swap) begin
         p_d   = x_in;
         c_d   = fp_neg(div_res);
         s_d   = 1'b1;
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!p_zero) begin
         c_d = fp_neg(div_res);
      end else if (!fp_is_zero(x_in)) begin
         sing_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q    <= '0;
         c_q    <= '0;
         s_q    <= 1'b0;
         cnt_q  <= '0;
         sing_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         c_q    <= c_d;
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         sing_q <= sing_d;
      end
   end

   assign c_out    = c_q;
   assign s_out    = s_q;
   assign p_out    = p_q;
   assign swap_cnt = cnt_q;
   assign singular = sing_q;

endmodule

`default_nettype wire
